// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared definitions for the 2-read/1-write register file with busy scoreboard.
// Provides the default geometry and the default-width address/data types
// used by the register file, its interface and its environment.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_NUM_REGS = 4;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0]           reg_data_t;

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Bus bundle between the decode/writeback side (master) and the register
// file (slave).
//   rd_addr_a/b   : read addresses          rd_data_a/b : read data
//   busy_a/b      : busy bit at read addr   busy_any    : OR of all busy bits
//   wr_en/addr/data : writeback port
//   claim_en/addr : destination claim       claim_ok    : claim accepted
interface regfile_2r1w_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = $clog2(DEFAULT_NUM_REGS)
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              busy_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;
    logic              claim_ok;
    logic              busy_any;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, claim_ok, busy_any
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, claim_ok, busy_any
    );

endinterface

// File: rtl/regfile_2r1w_sb_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_en_i, wr_addr_i: writeback, clears the busy bit of wr_addr_i
//   claim_en_i, claim_addr_i : claim request for a destination register
//   claim_ok_o        : claim accepted this cycle (combinational)
//   busy_o            : registered busy vector
//   busy_any_o        : OR of the registered busy vector
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic                claim_en_i,
    input  logic [ADDR_W-1:0]   claim_addr_i,
    output logic                claim_ok_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                busy_any_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // A busy register may be reclaimed only when its writeback lands in the
    // same cycle.
    always_comb begin
        claim_ok_o = claim_en_i & rst_n &
                     (~busy_q[claim_addr_i] | (wr_en_i & (wr_addr_i == claim_addr_i)));
    end

    // Clear first, then set: an accepted claim to the written address wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (claim_ok_o) begin
            busy_d[claim_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register busy scoreboard.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of regfile_2r1w_sb_if (reads, writeback, claims,
//                busy read-out)
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int BYPASS    = 1,
    parameter int REG0_INIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_2r1w_sb_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;
    logic                wr_live;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (bus.wr_en),
        .wr_addr_i    (bus.wr_addr),
        .claim_en_i   (bus.claim_en),
        .claim_addr_i (bus.claim_addr),
        .claim_ok_o   (bus.claim_ok),
        .busy_o       (busy_vec),
        .busy_any_o   (bus.busy_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= DATA_W'(REG0_INIT);
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Forwarding is suppressed during reset since that write is discarded.
    assign wr_live = (BYPASS != 0) & bus.wr_en & rst_n;

    always_comb begin
        bus.rd_data_a = mem_q[bus.rd_addr_a];
        if (wr_live && (bus.wr_addr == bus.rd_addr_a)) begin
            bus.rd_data_a = bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data_b = mem_q[bus.rd_addr_b];
        if (wr_live && (bus.wr_addr == bus.rd_addr_b)) begin
            bus.rd_data_b = bus.wr_data;
        end
    end

    // Busy read-out is never bypassed.
    assign bus.busy_a = busy_vec[bus.rd_addr_a];
    assign bus.busy_b = busy_vec[bus.rd_addr_b];

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench: one instance with bypass, one without, driven by the
// same stimulus and compared every cycle against a behavioural model.
module tb_regfile_2r1w_sb;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_addr_t rd_addr_a, rd_addr_b, wr_addr, claim_addr;
    reg_data_t wr_data;
    logic      wr_en, claim_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_2r1w_sb_if #(.DATA_W(8), .ADDR_W(2)) bus1 ();
    regfile_2r1w_sb_if #(.DATA_W(8), .ADDR_W(2)) bus0 ();

    assign bus1.rd_addr_a  = rd_addr_a;   assign bus0.rd_addr_a  = rd_addr_a;
    assign bus1.rd_addr_b  = rd_addr_b;   assign bus0.rd_addr_b  = rd_addr_b;
    assign bus1.wr_en      = wr_en;       assign bus0.wr_en      = wr_en;
    assign bus1.wr_addr    = wr_addr;     assign bus0.wr_addr    = wr_addr;
    assign bus1.wr_data    = wr_data;     assign bus0.wr_data    = wr_data;
    assign bus1.claim_en   = claim_en;    assign bus0.claim_en   = claim_en;
    assign bus1.claim_addr = claim_addr;  assign bus0.claim_addr = claim_addr;

    regfile_2r1w_sb #(.DATA_W(8), .NUM_REGS(4), .BYPASS(1), .REG0_INIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    regfile_2r1w_sb #(.DATA_W(8), .NUM_REGS(4), .BYPASS(0), .REG0_INIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    reg_data_t m_reg [4];
    bit        m_busy [4];
    bit        m_valid = 1'b0;

    function automatic bit m_claim_ok();
        return claim_en && rst_n && (!m_busy[claim_addr] || (wr_en && wr_addr == claim_addr));
    endfunction

    function automatic reg_data_t m_read(input reg_addr_t a, input bit bypass);
        if (bypass && wr_en && rst_n && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic bit m_any();
        return m_busy[0] || m_busy[1] || m_busy[2] || m_busy[3];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_reg[0] = 8'h01;
            for (int i = 1; i < 4; i++) m_reg[i] = 8'h00;
            for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            bit ok;
            ok = m_claim_ok();
            if (wr_en) begin
                m_reg[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (ok) m_busy[claim_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("byp_rd_a",   bus1.rd_data_a, m_read(rd_addr_a, 1'b1));
            check("byp_rd_b",   bus1.rd_data_b, m_read(rd_addr_b, 1'b1));
            check("nob_rd_a",   bus0.rd_data_a, m_read(rd_addr_a, 1'b0));
            check("nob_rd_b",   bus0.rd_data_b, m_read(rd_addr_b, 1'b0));
            check("busy_a",     bus1.busy_a,    m_busy[rd_addr_a]);
            check("busy_b",     bus1.busy_b,    m_busy[rd_addr_b]);
            check("claim_ok",   bus1.claim_ok,  m_claim_ok());
            check("busy_any",   bus1.busy_any,  m_any());
            check("nob_busy_a", bus0.busy_a,    m_busy[rd_addr_a]);
            check("nob_cl_ok",  bus0.claim_ok,  m_claim_ok());
            check("nob_any",    bus0.busy_any,  m_any());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; claim_en = 1'b0;
        wr_addr = '0; wr_data = '0; claim_addr = '0;
    endtask

    reg_data_t rst_vals [4];

    initial begin
        rst_vals = '{8'h01, 8'h00, 8'h00, 8'h00};
        rst_n = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        idle();
        tick();
        rst_n = 1'b1;

        // reset contents on both ports
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = reg_addr_t'(i);
            rd_addr_b = reg_addr_t'(3 - i);
            @(negedge clk);
            check("rst_rd_a", bus1.rd_data_a, rst_vals[i]);
            check("rst_rd_b", bus1.rd_data_b, rst_vals[3 - i]);
            check("rst_busy", {bus1.busy_a, bus1.busy_b, bus1.busy_any}, 3'b000);
            tick();
        end

        // bypass versus stored value
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A; rd_addr_a = 2'd2;
        @(negedge clk);
        check("byp_pre",  bus1.rd_data_a, 8'h5A);
        check("nob_pre",  bus0.rd_data_a, 8'h00);
        tick(); idle();
        @(negedge clk);
        check("byp_post", bus1.rd_data_a, 8'h5A);
        check("nob_post", bus0.rd_data_a, 8'h5A);
        tick();

        // claim, rejected re-claim, writeback
        claim_en = 1'b1; claim_addr = 2'd1; rd_addr_a = 2'd1;
        @(negedge clk);
        check("claim1_ok",   bus1.claim_ok, 1'b1);
        check("claim1_idle", bus1.busy_a,   1'b0);
        tick();
        @(negedge clk);
        check("claim1_busy", {bus1.busy_a, bus1.busy_any}, 2'b11);
        check("reclaim_rej", bus1.claim_ok, 1'b0);
        tick(); idle();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h33;
        @(negedge clk);
        check("wb_busy_held", bus1.busy_a,    1'b1);
        check("wb_byp",       bus1.rd_data_a, 8'h33);
        tick(); idle();
        @(negedge clk);
        check("wb_cleared", {bus1.busy_a, bus1.busy_any}, 2'b00);
        check("wb_data",    bus0.rd_data_a, 8'h33);
        tick();

        // same-cycle write and claim on a busy register
        claim_en = 1'b1; claim_addr = 2'd3;
        tick(); idle();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
        claim_en = 1'b1; claim_addr = 2'd3; rd_addr_a = 2'd3;
        @(negedge clk);
        check("wc_ok", bus1.claim_ok, 1'b1);
        tick(); idle();
        @(negedge clk);
        check("wc_busy", bus1.busy_a,    1'b1);
        check("wc_data", bus0.rd_data_a, 8'h77);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
        tick(); idle();

        // reset while registers are busy; inputs during reset ignored
        claim_en = 1'b1; claim_addr = 2'd0;
        tick();
        claim_addr = 2'd2;
        tick();
        rst_n = 1'b0;
        claim_en = 1'b1; claim_addr = 2'd1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hAA;
        @(negedge clk);
        check("rst_busy_any_pre", bus1.busy_any, 1'b1);
        check("rst_claim_off",    bus1.claim_ok, 1'b0);
        tick();
        rst_n = 1'b1; idle();
        rd_addr_a = 2'd0; rd_addr_b = 2'd2;
        @(negedge clk);
        check("mid_rst_r0",  bus1.rd_data_a, 8'h01);
        check("mid_rst_r2",  bus1.rd_data_b, 8'h00);
        check("mid_rst_any", bus1.busy_any,  1'b0);
        tick();
        rd_addr_a = 2'd1;
        @(negedge clk);
        check("mid_rst_r1", {bus1.busy_a, bus1.rd_data_a}, 9'h000);
        tick();

        // random traffic checked by the model
        for (int n = 0; n < 1000; n++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            rd_addr_a  = reg_addr_t'($urandom_range(0, 3));
            rd_addr_b  = reg_addr_t'($urandom_range(0, 3));
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_addr    = reg_addr_t'($urandom_range(0, 3));
            wr_data    = reg_data_t'($urandom_range(0, 255));
            claim_en   = ($urandom_range(0, 1) == 0);
            claim_addr = reg_addr_t'($urandom_range(0, 3));
            tick();
        end
        idle(); rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
